// File: rtl/conv_pkg.sv
// Shared types and constants for the convolutional-encoder framer.
// The optional CRC-8 trailer is selected with CONV_FRAMER_CRC_EN.
package conv_pkg;

    // Framer control states
    typedef enum logic [2:0] {
        S_IDLE,
        S_MASK0,
        S_MASK1,
        S_STALL,
        S_SHIFT,
        S_CRC,
        S_TAIL
    } state_t;

    // CRC-8 generator polynomial x^8 + x^2 + x + 1 (implicit x^8)
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Zero bits needed to flush an encoder with an n-stage shift register
    function automatic int tail_len(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/conv_crc8.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00, non-reflected) with a
// synchronous clear. Only instantiated when CONV_FRAMER_CRC_EN is defined.
module conv_crc8
    import conv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic feedback;

    assign feedback = crc[7] ^ bit_in;

    // Shift one message bit into the CRC register per enabled cycle
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        if (reset || clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/conv_framer.sv
// Frame serialiser feeding a programmable rate-1/2 convolutional encoder.
// Programs the encoder masks, shifts payload bytes MSB-first, optionally
// appends CRC-8 (CONV_FRAMER_CRC_EN), then N-1 zero tail bits. Input
// underflow freezes the encoder by rewriting mask0 with its current value.
module conv_framer
    import conv_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_we,
    input  logic [N-1:0] cfg_mask0,
    input  logic [N-1:0] cfg_mask1,
    input  logic         frm_start,
    input  logic [7:0]   frm_len,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic         enc_data_in,
    output logic [1:0]   enc_load_mask,
    output logic [N-1:0] enc_mask,
    output logic         out_valid,
    output logic         frame_done,
    output logic         busy
);

    localparam logic [7:0] TAIL_LAST = 8'(tail_len(N) - 1);

    state_t       state;
    state_t       state_next;
    logic [N-1:0] mask0_q;
    logic [N-1:0] mask1_q;
    logic [7:0]   data_reg;     // remaining bits of the byte (or CRC) being shifted
    logic [7:0]   cnt;          // bits left after the one currently driven
    logic [8:0]   bytes_left;   // payload bytes not yet accepted
    logic         hs;
    logic [1:0]   load_mask_next;
    logic [N-1:0] mask_next;

    // A byte is only wanted in STALL or during the last bit of a byte with more to come
    assign s_ready = (state == S_STALL) ||
                     ((state == S_SHIFT) && (cnt == 8'd0) && (bytes_left != 9'd0));
    assign hs      = s_valid & s_ready;

`ifdef CONV_FRAMER_CRC_EN
    logic [7:0] crc_out;
    logic       crc_clr;
    logic       crc_en;
    logic       crc_bit;

    // CRC tracks each payload bit as it is loaded onto enc_data_in, so the
    // value is complete while the last payload bit is on the wire.
    assign crc_clr = (state == S_IDLE) && !cfg_we && frm_start;
    assign crc_en  = hs || ((state == S_SHIFT) && (cnt != 8'd0));
    assign crc_bit = hs ? s_data[7] : data_reg[7];

    conv_crc8 u_crc (
        .clk    (clk),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc_out)
    );
`endif

    // Next-state decode plus the encoder control values for the next state
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_next     = state;
        load_mask_next = 2'b00;
        mask_next      = '0;

        case (state)
            S_IDLE: begin
                if (cfg_we) begin
                    state_next = S_MASK0;
                end else if (frm_start) begin
                    state_next = S_STALL;
                end
            end
            S_MASK0: state_next = S_MASK1;
            S_MASK1: state_next = S_IDLE;
            S_STALL: begin
                if (hs) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == 8'd0) begin
                    if (bytes_left != 9'd0) begin
                        state_next = hs ? S_SHIFT : S_STALL;
                    end else begin
`ifdef CONV_FRAMER_CRC_EN
                        state_next = S_CRC;
`else
                        state_next = S_TAIL;
`endif
                    end
                end
            end
`ifdef CONV_FRAMER_CRC_EN
            S_CRC: begin
                if (cnt == 8'd0) begin
                    state_next = S_TAIL;
                end
            end
`endif
            S_TAIL: begin
                if (cnt == 8'd0) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // MASK0 is entered only from IDLE on cfg_we, so the live cfg_mask0 is valid
        case (state_next)
            S_MASK0: begin
                load_mask_next = 2'b01;
                mask_next      = cfg_mask0;
            end
            S_MASK1: begin
                load_mask_next = 2'b10;
                mask_next      = mask1_q;
            end
            S_STALL: begin
                load_mask_next = 2'b01;
                mask_next      = mask0_q;
            end
            default: begin
                load_mask_next = 2'b00;
                mask_next      = '0;
            end
        endcase
    end

    // State register, datapath and registered encoder-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            mask0_q       <= '0;
            mask1_q       <= '0;
            data_reg      <= 8'h00;
            cnt           <= 8'd0;
            bytes_left    <= 9'd0;
            enc_data_in   <= 1'b0;
            enc_load_mask <= 2'b00;
            enc_mask      <= '0;
            out_valid     <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            busy          <= (state_next != S_IDLE);
            enc_load_mask <= load_mask_next;
            enc_mask      <= mask_next;
            // A symbol leaves the encoder one cycle after its bit is driven
            out_valid     <= (state == S_SHIFT) || (state == S_CRC) || (state == S_TAIL);
            frame_done    <= (state == S_TAIL) && (cnt == 8'd0);
            enc_data_in   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        mask0_q <= cfg_mask0;
                        mask1_q <= cfg_mask1;
                    end else if (frm_start) begin
                        bytes_left <= (frm_len == 8'd0) ? 9'd256 : {1'b0, frm_len};
                    end
                end
                S_STALL, S_SHIFT: begin
                    if (hs) begin
                        enc_data_in <= s_data[7];
                        data_reg    <= {s_data[6:0], 1'b0};
                        cnt         <= 8'd7;
                        bytes_left  <= bytes_left - 9'd1;
                    end else if (state == S_SHIFT) begin
                        if (cnt != 8'd0) begin
                            enc_data_in <= data_reg[7];
                            data_reg    <= {data_reg[6:0], 1'b0};
                            cnt         <= cnt - 8'd1;
                        end else if (bytes_left == 9'd0) begin
`ifdef CONV_FRAMER_CRC_EN
                            enc_data_in <= crc_out[7];
                            data_reg    <= {crc_out[6:0], 1'b0};
                            cnt         <= 8'd7;
`else
                            cnt         <= TAIL_LAST;
`endif
                        end
                    end
                end
`ifdef CONV_FRAMER_CRC_EN
                S_CRC: begin
                    if (cnt != 8'd0) begin
                        enc_data_in <= data_reg[7];
                        data_reg    <= {data_reg[6:0], 1'b0};
                        cnt         <= cnt - 8'd1;
                    end else begin
                        cnt <= TAIL_LAST;
                    end
                end
`endif
                S_TAIL: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/conv_framer.md
# conv_framer

Upstream feeder for the programmable rate-1/2 convolutional encoder. It accepts payload bytes over a valid/ready stream and programs the encoder's two generator masks. It serialises each frame MSB-first onto the encoder's `data_in`, optionally appends a CRC-8, and appends N-1 zero tail bits to flush the encoder to the all-zero state. Because the encoder shifts on every clock while `load_mask == 0`, the framer freezes it during input underflow by rewriting mask0 with its unchanged value.

## Interface
- `N`, 6, encoder shift-register length; must match the encoder instance. Tail length = N-1.
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `cfg_we`  in  1  request mask programming; honoured only in IDLE.
- `cfg_mask0`, `cfg_mask1`  in  N each  generator patterns, MSB set.
- `frm_start`  in  1  start a frame; honoured only in IDLE.
- `frm_len`  in  8  payload bytes, sampled with `frm_start`; 0 means 256.
- `s_data`  in  8  payload byte.
- `s_valid`  in  1  byte valid.
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`.
- `enc_data_in`  out  1  to encoder `data_in`.
- `enc_load_mask`  out  2  to encoder `load_mask`.
- `enc_mask`  out  N  to encoder `mask`.
- `out_valid`  out  1  encoder `data_out` carries a frame symbol this cycle.
- `frame_done`  out  1  one-cycle pulse with the last tail symbol's `out_valid`.
- `busy`  out  1  state ≠ IDLE.

## Operation
- All outputs are registered except `s_ready`, which is decoded from state and counters.
- Reset values: state IDLE; all outputs 0; shadow masks 0; CRC 0; all counters 0.
- States: IDLE, MASK0, MASK1, STALL, SHIFT, CRC, TAIL.
- IDLE: drive `enc_load_mask`=00 and `enc_data_in`=0. The encoder shifts zeros and holds its flushed state.
- If `cfg_we` and `frm_start` are both high in IDLE, `cfg_we` wins and `frm_start` is dropped.
- `cfg_we` in IDLE: go to MASK0, then MASK1, then IDLE.
  - MASK0: `enc_load_mask`=01, `enc_mask`=mask0.
  - MASK1: `enc_load_mask`=10, `enc_mask`=mask1.
  - Both cfg masks are captured into shadow registers on acceptance.
- `frm_start` in IDLE: latch `frm_len`, clear the CRC, go to STALL.
- STALL: `s_ready`=1, `enc_load_mask`=01, `enc_mask`=shadow mask0. This freezes the encoder state; `out_valid` is 0.
  - On handshake, load the byte and go to SHIFT.
- SHIFT: drive bits 7..0, one per cycle.
  - `s_ready`=1 during the bit-0 cycle if bytes remain. A handshake there continues SHIFT with no bubble; no handshake goes to STALL.
  - After bit 0 of the last byte, go to CRC (macro defined) or TAIL.
- CRC: shift out the 8 CRC bits, MSB-first.
- TAIL: drive N-1 zeros, then go to IDLE.
- Frame-symbol cycles (SHIFT, CRC, TAIL) drive `enc_load_mask`=00.
- `s_data` is ignored whenever `s_ready`=0.
- `reset` mid-frame aborts immediately. The encoder's own state is not flushed by the framer.
- Until the first mask programming after reset, STALL rewrites encoder mask0 with 0. Software programs masks before the first frame.

## Timing
- `cfg_we` in cycle c: MASK0 in c+1, MASK1 in c+2, IDLE in c+3.
- `frm_start` in cycle c: STALL and `s_ready` in c+1.
- Byte handshake at the end of cycle c:
  - bit7 on `enc_data_in` in c+1.
  - The encoder shifts it at the end of c+1.
  - `out_valid`=1 in c+2.
- Latency from handshake to first symbol: 2 cycles.
- No-stall frame of L bytes: 8L + 8·CRC + (N-1) consecutive `out_valid` cycles.
- `out_valid` is the 1-cycle-delayed "frame bit driven" flag. STALL cycles insert `out_valid`=0 gaps.
- `frame_done` fires in the cycle after the last tail bit is driven, coincident with its `out_valid`.

## Configuration
- `CONV_FRAMER_CRC_EN` defined:
  - CRC-8, poly 0x07, init 0x00, non-reflected, computed bit-serially over payload bits.
  - Appended after the payload, MSB-first.
- Not defined: no CRC state and no CRC logic; payload goes directly to the tail.

## Structure
- `conv_pkg` holds:
  - the state enum;
  - `CRC8_POLY` = 8'h07;
  - a `tail_len(N)` function.
- Sub-module `conv_crc8`: bit-serial CRC with clear, enable, bit in, 8-bit out. Instantiated only under `CONV_FRAMER_CRC_EN`.

## Test plan
- Reset mid-frame (during SHIFT): next cycle `busy`=0, `s_ready`=0, `enc_load_mask`=00, `out_valid`=0.
- `cfg_we` with mask0=6'b100000, mask1=6'b100001: `enc_load_mask` is 01 then 10 with the matching `enc_mask`, `busy` for 2 cycles. An encoder model holds both masks.
- Frame of 1 byte 0xA5, CRC off, N=6, masks as above:
  - `data_out[0]` on `out_valid` = 1,0,1,0,0,1,0,1,0,0,0,0,0;
  - 13 symbols, `frame_done` on the 13th.
- Frame of 1 byte 0x01 with CRC on: CRC symbols on `data_out[0]` = 0,0,0,0,0,1,1,1 (0x07).
- Two-byte frame, `s_valid` dropped for 3 cycles between the bytes:
  - 3 STALL cycles with `enc_load_mask`=01 and `out_valid`=0;
  - encoder state unchanged across the gap;
  - bit stream identical to the no-gap case.
- `frm_len`=0 with continuous `s_valid`: exactly 256 handshakes, then tail. Simultaneous `cfg_we` and `frm_start` in IDLE: masks load and no frame starts.
